// File: rtl/mem_arbiter.sv
// Two-master arbiter for the single RAM port: master 0 has priority, master 1 is guaranteed a slot after STARVE_MAX grants.
// Grant is zero-latency, read data returns one cycle after grant; an ungranted requester just keeps req high (no queueing).
module mem_arbiter #(
   parameter int AW         = 32,
   parameter int DW         = 32,
   parameter int STARVE_MAX = 4
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          m0_req,
   input  logic          m0_we,
   input  logic [AW-1:0] m0_addr,
   input  logic [DW-1:0] m0_wdata,
   output logic          m0_gnt,
   output logic          m0_rvalid,
   output logic [DW-1:0] m0_rdata,
   input  logic          m1_req,
   input  logic          m1_we,
   input  logic [AW-1:0] m1_addr,
   input  logic [DW-1:0] m1_wdata,
   output logic          m1_gnt,
   output logic          m1_rvalid,
   output logic [DW-1:0] m1_rdata,
   output logic          ram_we_o,
   output logic [AW-1:0] ram_addr_o,
   output logic [DW-1:0] ram_data_o,
   input  logic [DW-1:0] ram_data_i
);

   localparam logic [3:0] SMAX = 4'(STARVE_MAX);

   logic [3:0]    starve_cnt;
   logic [1:0]    rd_owner;
   logic [AW-1:0] last_addr;
   logic          gnt0;
   logic          gnt1;

   // Grants are gated by reset so nothing reaches the RAM while reset is held.
   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if (reset) begin
         if (m0_req && m1_req) begin
            if (starve_cnt >= SMAX) gnt1 = 1'b1;
            else                    gnt0 = 1'b1;
         end else if (m0_req) begin
            gnt0 = 1'b1;
         end else if (m1_req) begin
            gnt1 = 1'b1;
         end
      end
   end

   always_comb begin
      ram_we_o   = 1'b0;
      ram_addr_o = last_addr;
      ram_data_o = '0;
      if (gnt0) begin
         ram_we_o   = m0_we;
         ram_addr_o = m0_addr;
         ram_data_o = m0_wdata;
      end else if (gnt1) begin
         ram_we_o   = m1_we;
         ram_addr_o = m1_addr;
         ram_data_o = m1_wdata;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         starve_cnt <= '0;
         rd_owner   <= 2'b00;
         last_addr  <= '0;
      end else begin
         if (gnt0 && m1_req) begin
            if (starve_cnt < SMAX) starve_cnt <= starve_cnt + 4'd1;
         end else begin
            starve_cnt <= '0;
         end
         rd_owner <= {gnt1 & ~m1_we, gnt0 & ~m0_we};
         if (gnt0 || gnt1) last_addr <= ram_addr_o;
      end
   end

   assign m0_gnt    = gnt0;
   assign m1_gnt    = gnt1;
   assign m0_rvalid = rd_owner[0];
   assign m1_rvalid = rd_owner[1];
   assign m0_rdata  = rd_owner[0] ? ram_data_i : '0;
   assign m1_rdata  = rd_owner[1] ? ram_data_i : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a 256-word RAM model (one-cycle read latency).
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        m0_req = 1'b0, m0_we = 1'b0;
   logic [31:0] m0_addr = '0, m0_wdata = '0;
   logic        m0_gnt, m0_rvalid;
   logic [31:0] m0_rdata;
   logic        m1_req = 1'b0, m1_we = 1'b0;
   logic [31:0] m1_addr = '0, m1_wdata = '0;
   logic        m1_gnt, m1_rvalid;
   logic [31:0] m1_rdata;
   logic        ram_we_o;
   logic [31:0] ram_addr_o, ram_data_o, ram_data_i;

   int total = 0;
   int bad   = 0;

   mem_arbiter #(.AW(32), .DW(32), .STARVE_MAX(4)) dut (
      .clk(clk), .reset(reset),
      .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
      .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
      .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
      .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
      .ram_we_o(ram_we_o), .ram_addr_o(ram_addr_o), .ram_data_o(ram_data_o),
      .ram_data_i(ram_data_i)
   );

   always #5 clk = ~clk;

   // Unwritten words read as 0xA5A500xx where xx is the word address.
   logic [31:0] mem [0:255];
   logic        written [0:255];
   always @(posedge clk) begin
      if (!reset) begin
         for (int i = 0; i < 256; i++) written[i] <= 1'b0;
      end else if (ram_we_o) begin
         mem[ram_addr_o[7:0]]     <= ram_data_o;
         written[ram_addr_o[7:0]] <= 1'b1;
      end
      ram_data_i <= written[ram_addr_o[7:0]] ? mem[ram_addr_o[7:0]]
                                              : (32'hA5A50000 | {24'h0, ram_addr_o[7:0]});
   end

   task automatic next_cycle;
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs;
      m0_req = 1'b0; m0_we = 1'b0; m0_addr = '0; m0_wdata = '0;
      m1_req = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_wdata = '0;
   endtask

   task automatic test_reset;
      m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h4;
      m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h8; m1_wdata = 32'h1111_2222;
      next_cycle;
      next_cycle;
      @(negedge clk);
      total++;
      if ({m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, ram_we_o} !== 5'b0 ||
          ram_addr_o !== 32'h0 || ram_data_o !== 32'h0 || m0_rdata !== 32'h0 || m1_rdata !== 32'h0) begin
         bad++;
         $display("FAIL reset_outputs: gnt=%b%b rv=%b%b we=%b addr=%h data=%h rd0=%h rd1=%h, want all zero",
                  m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, ram_we_o, ram_addr_o, ram_data_o, m0_rdata, m1_rdata);
      end
      next_cycle;
      reset = 1'b1;
      @(negedge clk);
      total++;
      if (m0_gnt !== 1'b1 || m1_gnt !== 1'b0 || ram_addr_o !== 32'h4) begin
         bad++;
         $display("FAIL reset_first_grant: m0_gnt=%b m1_gnt=%b addr=%h, want 1 0 00000004", m0_gnt, m1_gnt, ram_addr_o);
      end
      next_cycle;
      idle_inputs;
      @(negedge clk);
      total++;
      if (m0_rvalid !== 1'b1 || m0_rdata !== 32'hA5A50004 || m1_rvalid !== 1'b0) begin
         bad++;
         $display("FAIL reset_first_read: m0_rvalid=%b m0_rdata=%h m1_rvalid=%b, want 1 a5a50004 0", m0_rvalid, m0_rdata, m1_rvalid);
      end
      next_cycle;
   endtask

   task automatic test_single_master;
      m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h10; m1_wdata = 32'hDEADBEEF;
      @(negedge clk);
      total++;
      if (m1_gnt !== 1'b1 || m0_gnt !== 1'b0 || ram_we_o !== 1'b1 || ram_addr_o !== 32'h10 || ram_data_o !== 32'hDEADBEEF) begin
         bad++;
         $display("FAIL single_write: gnt=%b%b we=%b addr=%h data=%h, want 01 1 00000010 deadbeef",
                  m0_gnt, m1_gnt, ram_we_o, ram_addr_o, ram_data_o);
      end
      next_cycle;
      m1_we = 1'b0; m1_wdata = '0;
      @(negedge clk);
      total++;
      if (m1_gnt !== 1'b1 || ram_we_o !== 1'b0 || ram_addr_o !== 32'h10 || m1_rvalid !== 1'b0 || m0_rvalid !== 1'b0) begin
         bad++;
         $display("FAIL single_read_issue: m1_gnt=%b we=%b addr=%h rv=%b%b, want 1 0 00000010 00",
                  m1_gnt, ram_we_o, ram_addr_o, m0_rvalid, m1_rvalid);
      end
      next_cycle;
      idle_inputs;
      @(negedge clk);
      total++;
      if (m1_rvalid !== 1'b1 || m1_rdata !== 32'hDEADBEEF || m0_rvalid !== 1'b0 || m0_rdata !== 32'h0) begin
         bad++;
         $display("FAIL single_read_return: m1_rvalid=%b m1_rdata=%h m0_rvalid=%b m0_rdata=%h, want 1 deadbeef 0 0",
                  m1_rvalid, m1_rdata, m0_rvalid, m0_rdata);
      end
      next_cycle;
   endtask

   task automatic test_starvation;
      logic [9:0] pat;
      pat = 10'b10_0001_0000;
      m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h40;
      m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h80;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         total++;
         if (m1_gnt !== pat[i] || m0_gnt !== ~pat[i]) begin
            bad++;
            $display("FAIL starve_pattern[%0d]: m0_gnt=%b m1_gnt=%b, want %b %b", i, m0_gnt, m1_gnt, ~pat[i], pat[i]);
         end
         next_cycle;
      end
      // Three m0 wins, then m1 drops for one cycle: the count must restart from zero.
      for (int i = 0; i < 3; i++) next_cycle;
      m1_req = 1'b0;
      next_cycle;
      m1_req = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         total++;
         if (m1_gnt !== (i == 4) || m0_gnt !== (i != 4)) begin
            bad++;
            $display("FAIL starve_after_drop[%0d]: m0_gnt=%b m1_gnt=%b, want %b %b", i, m0_gnt, m1_gnt, (i != 4), (i == 4));
         end
         next_cycle;
      end
      idle_inputs;
      next_cycle;
   endtask

   task automatic test_alternating_reads;
      m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h4;
      @(negedge clk);
      total++;
      if (m0_gnt !== 1'b1 || m1_gnt !== 1'b0) begin
         bad++;
         $display("FAIL alt_m0_grant: m0_gnt=%b m1_gnt=%b, want 1 0", m0_gnt, m1_gnt);
      end
      next_cycle;
      m0_req = 1'b0; m0_addr = '0;
      m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h8;
      @(negedge clk);
      total++;
      if (m1_gnt !== 1'b1 || m0_rvalid !== 1'b1 || m0_rdata !== 32'hA5A50004 || m1_rvalid !== 1'b0 || m1_rdata !== 32'h0) begin
         bad++;
         $display("FAIL alt_m0_return: m1_gnt=%b m0_rv=%b m0_rd=%h m1_rv=%b m1_rd=%h, want 1 1 a5a50004 0 0",
                  m1_gnt, m0_rvalid, m0_rdata, m1_rvalid, m1_rdata);
      end
      next_cycle;
      idle_inputs;
      @(negedge clk);
      total++;
      if (m1_rvalid !== 1'b1 || m1_rdata !== 32'hA5A50008 || m0_rvalid !== 1'b0 || m0_rdata !== 32'h0) begin
         bad++;
         $display("FAIL alt_m1_return: m1_rv=%b m1_rd=%h m0_rv=%b m0_rd=%h, want 1 a5a50008 0 0",
                  m1_rvalid, m1_rdata, m0_rvalid, m0_rdata);
      end
      next_cycle;
   endtask

   task automatic test_idle;
      m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h20; m0_wdata = 32'h1234_5678;
      next_cycle;
      idle_inputs;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         total++;
         if (ram_we_o !== 1'b0 || ram_addr_o !== 32'h20 || ram_data_o !== 32'h0 ||
             {m0_gnt, m1_gnt, m0_rvalid, m1_rvalid} !== 4'b0) begin
            bad++;
            $display("FAIL idle[%0d]: we=%b addr=%h data=%h gnt=%b%b rv=%b%b, want 0 00000020 0 00 00",
                     i, ram_we_o, ram_addr_o, ram_data_o, m0_gnt, m1_gnt, m0_rvalid, m1_rvalid);
         end
         next_cycle;
      end
   endtask

   task automatic test_reset_mid_read;
      logic seen;
      seen = 1'b0;
      m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h30;
      @(negedge clk);
      total++;
      if (m0_gnt !== 1'b1) begin
         bad++;
         $display("FAIL midrd_grant: m0_gnt=%b, want 1", m0_gnt);
      end
      #1;
      reset = 1'b0;
      idle_inputs;
      for (int i = 0; i < 3; i++) begin
         next_cycle;
         if (m0_rvalid === 1'b1) seen = 1'b1;
         if (i == 1) reset = 1'b1;
         @(negedge clk);
         if (m0_rvalid === 1'b1) seen = 1'b1;
      end
      total++;
      if (seen !== 1'b0) begin
         bad++;
         $display("FAIL midrd_rvalid: m0_rvalid pulsed=%b, want 0", seen);
      end
      total++;
      if (dut.rd_owner !== 2'b00 || m1_rvalid !== 1'b0) begin
         bad++;
         $display("FAIL midrd_owner: rd_owner=%b m1_rvalid=%b, want 00 0", dut.rd_owner, m1_rvalid);
      end
      next_cycle;
   endtask

   initial begin
      test_reset;
      test_single_master;
      test_starvation;
      test_alternating_reads;
      test_idle;
      test_reset_mid_read;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
